// File: rtl/mpmc11_app_cmd_seq.sv
// mpmc11_app_cmd_seq: sequences one multi-burst read/write transaction onto the MIG app interface
// Ports: clk/rst_n (async active-low); calib_done gates acceptance;
//   req/we/adr/len request (sampled in IDLE); wdat/wmask/wdat_ack write-beat source handshake;
//   busy/ack status; app_en/app_cmd/app_addr/app_rdy command channel;
//   app_wdf_wren/app_wdf_end/app_wdf_data/app_wdf_mask/app_wdf_rdy write-data channel.
module mpmc11_app_cmd_seq #(
    parameter int AW       = 29,
    parameter int DW       = 128,
    parameter int BEATS    = 2,
    parameter int ADDR_INC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            calib_done,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   adr,
    input  logic [5:0]      len,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wmask,
    output logic            wdat_ack,
    output logic            busy,
    output logic            ack,
    output logic            app_en,
    output logic [2:0]      app_cmd,
    output logic [AW-1:0]   app_addr,
    input  logic            app_rdy,
    output logic            app_wdf_wren,
    output logic            app_wdf_end,
    output logic [DW-1:0]   app_wdf_data,
    output logic [DW/8-1:0] app_wdf_mask,
    input  logic            app_wdf_rdy
);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, DONE} state_t;
    state_t state, state_n;
    logic we_r, we_n, beat, beat_n, last;
    logic [AW-1:0] addr_r, addr_n;
    logic [5:0] bcnt, bcnt_n;
    assign last         = beat == 1'(BEATS - 1);
    assign busy         = state != IDLE;
    assign ack          = state == DONE;
    assign app_en       = state == WR_CMD || state == RD_CMD;
    assign app_cmd      = state == RD_CMD ? 3'b001 : 3'b000;
    assign app_addr     = addr_r;
    assign app_wdf_wren = state == WR_DATA;
    assign app_wdf_end  = app_wdf_wren && last;
    assign wdat_ack     = app_wdf_wren && app_wdf_rdy;
    assign app_wdf_data = wdat;
    assign app_wdf_mask = wmask;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            we_r   <= 1'b0;
            addr_r <= '0;
            bcnt   <= '0;
            beat   <= 1'b0;
        end else begin
            state  <= state_n;
            we_r   <= we_n;
            addr_r <= addr_n;
            bcnt   <= bcnt_n;
            beat   <= beat_n;
        end
    end
    always_comb begin
        state_n = state;
        we_n    = we_r;
        addr_n  = addr_r;
        bcnt_n  = bcnt;
        beat_n  = beat;
        case (state)
            IDLE: if (req && calib_done) begin
                we_n    = we;
                addr_n  = adr;
                bcnt_n  = len;
                beat_n  = 1'b0;
                state_n = we ? WR_DATA : RD_CMD;
            end
            WR_DATA: if (app_wdf_rdy) begin
                beat_n  = last ? 1'b0 : beat + 1'b1;
                state_n = last ? WR_CMD : WR_DATA;
            end
            WR_CMD, RD_CMD: if (app_rdy) begin
                if (bcnt == '0) state_n = DONE;
                else begin
                    bcnt_n  = bcnt - 6'd1;
                    addr_n  = addr_r + AW'(ADDR_INC);
                    state_n = we_r ? WR_DATA : RD_CMD;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule
